// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, error-flag bit positions
// and the bit-period calculation used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;
    localparam int ERR_BREAK  = 2;

    function automatic int clks_per_bit(input int sysclk_rate, input int baud_rate);
        return sysclk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous line inputs (Rx, CTS); the reset
// value is a parameter so idle-high lines do not look active out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic SysClk,
    input  logic Rst_n,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            meta <= RST_VAL;
            Q    <= RST_VAL;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: recovers start/data/parity/stop framing from the
// synchronised Rx line and presents a parallel word plus error flags.
//
// state      | meaning
// IDLE       | line idle, waiting for a low level
// START      | timing to start-bit centre, rejecting glitches
// DATA       | shifting in data bits MSB first at bit centres
// PARITY     | sampling the even-parity bit
// STOP       | sampling stop bits, then completing the frame
// BREAK_WAIT | line still low after a frame, wait for it to return high
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst_n,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 Rx_Busy
);

    localparam int CPB = clks_per_bit(SYSCLK_RATE, BAUD_RATE);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_TC   = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] BIT_TC    = CW'(CPB - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    rx_state_t            state_q, state_d;
    logic                 rx_s;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 stop_err_q;
    logic                 stop_low_q;
    logic                 fin_q;
    logic                 half_hit;
    logic                 bit_hit;
    logic                 complete;
    logic                 par_err;
    logic                 brk;
    logic [2:0]           err_d;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
        .SysClk (SysClk),
        .Rst_n  (Rst_n),
        .D      (Rx),
        .Q      (rx_s)
    );

    assign half_hit = (baud_cnt == HALF_TC);
    assign bit_hit  = (baud_cnt == BIT_TC);
    assign par_err  = (PARITY_BIT != 0) && (par_q ^ (^shift_q));
    // A break is an all-zero frame including parity and every stop bit.
    assign brk      = (shift_q == '0) && !par_q && stop_low_q;

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        err_d    = '0;
        case (state_q)
            IDLE:       if (!rx_s) state_d = START;
            START:      if (half_hit) state_d = rx_s ? IDLE : DATA;
            DATA:       if (bit_hit && (bit_cnt == DATA_LAST))
                            state_d = (PARITY_BIT != 0) ? PARITY : STOP;
            PARITY:     if (bit_hit) state_d = STOP;
            STOP: begin
                if (fin_q) begin
                    complete = 1'b1;
                    state_d  = rx_s ? IDLE : BREAK_WAIT;
                end
            end
            BREAK_WAIT: if (rx_s) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (brk) begin
            err_d[ERR_BREAK] = 1'b1;
        end else begin
            err_d[ERR_FRAME]  = stop_err_q;
            err_d[ERR_PARITY] = par_err;
        end
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_err_q <= 1'b0;
            stop_low_q <= 1'b0;
            fin_q      <= 1'b0;
            Data_Out   <= '0;
            Data_Rdy   <= 1'b0;
            Rx_Error   <= '0;
            Rx_Busy    <= 1'b0;
        end else begin
            Data_Rdy <= 1'b0;
            Rx_Busy  <= (state_d != IDLE);
            // Restarting on every state change keeps later samples at bit centres.
            baud_cnt <= ((state_d != state_q) || bit_hit) ? '0 : baud_cnt + 1'b1;

            if (state_d != state_q) begin
                bit_cnt <= '0;
            end else if (bit_hit && ((state_q == DATA) || (state_q == STOP))) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if ((state_q == DATA) && bit_hit) begin
                shift_q <= {shift_q[DATA_BITS-2:0], rx_s};
            end
            if ((state_q == PARITY) && bit_hit) begin
                par_q <= rx_s;
            end

            if ((state_q != STOP) && (state_d == STOP)) begin
                stop_err_q <= 1'b0;
                stop_low_q <= 1'b1;
                fin_q      <= 1'b0;
            end else if ((state_q == STOP) && bit_hit && !fin_q) begin
                stop_err_q <= stop_err_q | ~rx_s;
                stop_low_q <= stop_low_q & ~rx_s;
                if (bit_cnt == STOP_LAST) fin_q <= 1'b1;
            end

            if (complete) begin
                Data_Out <= shift_q;
                Data_Rdy <= 1'b1;
                Rx_Error <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 16 clocks per bit, 8E2 framing.
module tb_uart_rx_deframer;

    localparam int CPB = 16;

    logic       SysClk = 1'b0;
    logic       Rst_n;
    logic       Rx;
    logic [7:0] Data_Out;
    logic       Data_Rdy;
    logic [2:0] Rx_Error;
    logic       Rx_Busy;

    int tests   = 0;
    int fails   = 0;
    int rdy_cnt = 0;
    int base;

    uart_rx_deframer #(
        .SYSCLK_RATE (1600000),
        .BAUD_RATE   (100000),
        .DATA_BITS   (8),
        .PARITY_BIT  (1),
        .STOP_BITS   (2)
    ) dut (
        .SysClk   (SysClk),
        .Rst_n    (Rst_n),
        .Rx       (Rx),
        .Data_Out (Data_Out),
        .Data_Rdy (Data_Rdy),
        .Rx_Error (Rx_Error),
        .Rx_Busy  (Rx_Busy)
    );

    always #5 SysClk = ~SysClk;

    always @(posedge SysClk) if (Data_Rdy === 1'b1) rdy_cnt <= rdy_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        repeat (CPB) @(negedge SysClk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic [1:0] stops);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit((^d) ^ flip);
        send_bit(stops[1]);
        send_bit(stops[0]);
    endtask

    initial begin
        Rx    = 1'b1;
        Rst_n = 1'b0;
        repeat (3) @(negedge SysClk);
        check("rst_data_out", 32'(Data_Out), 32'h0);
        check("rst_data_rdy", 32'(Data_Rdy), 32'h0);
        check("rst_rx_error", 32'(Rx_Error), 32'h0);
        check("rst_rx_busy",  32'(Rx_Busy),  32'h0);
        Rst_n = 1'b1;
        send_idle(2);
        check("idle_busy", 32'(Rx_Busy), 32'h0);

        // 0xA5, good parity; latency counted from the first edge that captures the falling Rx
        base = rdy_cnt;
        fork
            send_frame(8'hA5, 1'b0, 2'b11);
            begin
                @(posedge SysClk);
                repeat (186) @(posedge SysClk);
                #1 check("a5_rdy_before", 32'(Data_Rdy), 32'h0);
                @(posedge SysClk);
                #1 check("a5_rdy_at_187", 32'(Data_Rdy), 32'h1);
                @(posedge SysClk);
                #1 check("a5_rdy_after", 32'(Data_Rdy), 32'h0);
            end
        join
        check("a5_data", 32'(Data_Out), 32'hA5);
        check("a5_err",  32'(Rx_Error), 32'h0);
        check("a5_count", 32'(rdy_cnt - base), 32'd1);
        send_idle(2);

        base = rdy_cnt;
        send_frame(8'h3C, 1'b1, 2'b11);
        check("3c_data", 32'(Data_Out), 32'h3C);
        check("3c_err",  32'(Rx_Error), 32'h1);
        check("3c_count", 32'(rdy_cnt - base), 32'd1);
        send_idle(2);

        base = rdy_cnt;
        send_frame(8'h81, 1'b0, 2'b00);
        send_idle(2);
        check("81_data", 32'(Data_Out), 32'h81);
        check("81_err",  32'(Rx_Error), 32'h2);
        check("81_count", 32'(rdy_cnt - base), 32'd1);
        check("81_busy", 32'(Rx_Busy), 32'h0);

        // Break: line low for 15 bit times
        base = rdy_cnt;
        Rx = 1'b0;
        repeat (15 * CPB) @(negedge SysClk);
        check("brk_busy_low", 32'(Rx_Busy), 32'h1);
        check("brk_count", 32'(rdy_cnt - base), 32'd1);
        check("brk_data", 32'(Data_Out), 32'h0);
        check("brk_err",  32'(Rx_Error), 32'h4);
        Rx = 1'b1;
        repeat (4) @(negedge SysClk);
        check("brk_busy_released", 32'(Rx_Busy), 32'h0);
        send_idle(2);
        check("brk_single", 32'(rdy_cnt - base), 32'd1);

        // 4-cycle glitch
        base = rdy_cnt;
        Rx = 1'b0;
        @(posedge SysClk);
        repeat (3) @(posedge SysClk);
        #1 check("glitch_busy_high", 32'(Rx_Busy), 32'h1);
        @(negedge SysClk);
        Rx = 1'b1;
        repeat (8) @(posedge SysClk);
        #1 check("glitch_busy_clear", 32'(Rx_Busy), 32'h0);
        send_idle(2);
        check("glitch_no_rdy", 32'(rdy_cnt - base), 32'd0);

        // Back-to-back frames
        base = rdy_cnt;
        send_frame(8'h00, 1'b0, 2'b11);
        check("b2b0_data", 32'(Data_Out), 32'h00);
        check("b2b0_err",  32'(Rx_Error), 32'h0);
        send_frame(8'hFF, 1'b0, 2'b11);
        check("b2b1_data", 32'(Data_Out), 32'hFF);
        check("b2b1_err",  32'(Rx_Error), 32'h0);
        send_frame(8'h55, 1'b0, 2'b11);
        check("b2b2_data", 32'(Data_Out), 32'h55);
        check("b2b2_err",  32'(Rx_Error), 32'h0);
        send_idle(1);
        check("b2b_count", 32'(rdy_cnt - base), 32'd3);
        send_idle(1);

        // Reset mid-frame during data bit 4 of 0x77 (bits 0,1,1,1,0 ...)
        base = rdy_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        Rx = 1'b0;
        repeat (CPB / 2) @(negedge SysClk);
        Rst_n = 1'b0;
        Rx    = 1'b1;
        @(negedge SysClk);
        check("mid_rst_busy", 32'(Rx_Busy),  32'h0);
        check("mid_rst_data", 32'(Data_Out), 32'h0);
        check("mid_rst_err",  32'(Rx_Error), 32'h0);
        repeat (4) @(negedge SysClk);
        Rst_n = 1'b1;
        send_idle(3);
        check("mid_rst_no_rdy", 32'(rdy_cnt - base), 32'd0);
        send_frame(8'h12, 1'b0, 2'b11);
        check("post_rst_data", 32'(Data_Out), 32'h12);
        check("post_rst_err",  32'(Rx_Error), 32'h0);
        check("post_rst_count", 32'(rdy_cnt - base), 32'd1);
        send_idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
